fixed_point_dot_product: RTL and testbench

Sequential dot-product engine built around the team's Q-format multiply-add rule. It accepts a stream of Vector_Length operand pairs over a valid/ready handshake and multiplies each pair. Each product is truncated back to Word_Length and accumulated into a registered Q-format accumulator. The final sum is then presented on a result handshake. It sits downstream of the operand source (register file or FIFO) and feeds the result consumer.

---
 rtl/fixed_point_pkg.sv | 24 ++
 rtl/fixed_point_mul_trunc.sv | 25 ++
 rtl/fixed_point_dot_product.sv | 119 +++++++++++
 tb/tb_fixed_point_dot_product.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point dot-product engine.
package fixed_point_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  // Bit positions of the product slice that realigns a full-width product
  // back to the operand Q-format.
  function automatic int unsigned trunc_msb(int unsigned wl, int unsigned fp);
    return wl + fp - 1;
  endfunction

  function automatic int unsigned trunc_lsb(int unsigned fp);
    return fp;
  endfunction

  function automatic int sat_max(int unsigned wl);
    return (1 << (wl - 1)) - 1;
  endfunction

  function automatic int sat_min(int unsigned wl);
    return -(1 << (wl - 1));
  endfunction

endpackage

// File: rtl/fixed_point_mul_trunc.sv
// Combinational signed Q-format multiply, sliced back to Word_Length bits.
// The dropped low bits floor the product (round toward minus infinity).
module fixed_point_mul_trunc
  import fixed_point_pkg::*;
#(
  parameter int unsigned Word_Length     = 6,
  parameter int unsigned Fractional_Part = 3
) (
  input  logic signed [Word_Length-1:0] a_i,
  input  logic signed [Word_Length-1:0] b_i,
  output logic signed [Word_Length-1:0] term_o
);

  localparam int unsigned ProdW = 2 * Word_Length;
  localparam int unsigned TMsb  = trunc_msb(Word_Length, Fractional_Part);
  localparam int unsigned TLsb  = trunc_lsb(Fractional_Part);

  logic signed [ProdW-1:0] prod;
  logic                    unused_prod;

  assign prod        = ProdW'(a_i) * ProdW'(b_i);
  assign term_o      = prod[TMsb:TLsb];
  assign unused_prod = ^prod;

endmodule

// File: rtl/fixed_point_dot_product.sv
// Sequential Q-format dot-product engine with valid/ready operand and result ports.
// Define FIXED_POINT_SATURATE_EN for a saturating accumulator (default: wrap).
module fixed_point_dot_product
  import fixed_point_pkg::*;
#(
  parameter int unsigned Word_Length     = 6,
  parameter int unsigned Integer_Part    = 3,
  parameter int unsigned Fractional_Part = Word_Length - Integer_Part,
  parameter int unsigned Vector_Length   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [Word_Length-1:0] a_in,
  input  logic signed [Word_Length-1:0] b_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [Word_Length-1:0] result,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic                          busy
);

  localparam int unsigned     CntW    = $clog2(Vector_Length) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Vector_Length - 1);

  state_e                        state_q, state_d;
  logic signed [Word_Length-1:0] acc_q, acc_d;
  logic signed [Word_Length-1:0] result_q, result_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          rv_q, rv_d;
  logic signed [Word_Length-1:0] term;
  logic signed [Word_Length-1:0] acc_next;

  fixed_point_mul_trunc #(
    .Word_Length    (Word_Length),
    .Fractional_Part(Fractional_Part)
  ) u_mul (
    .a_i   (a_in),
    .b_i   (b_in),
    .term_o(term)
  );

`ifdef FIXED_POINT_SATURATE_EN
  localparam logic signed [Word_Length-1:0] SatMax = Word_Length'(sat_max(Word_Length));
  localparam logic signed [Word_Length-1:0] SatMin = Word_Length'(sat_min(Word_Length));

  logic signed [Word_Length:0] sum_ext;

  // Overflow shows as disagreement between the two top bits of the widened sum.
  always_comb begin
    sum_ext = {acc_q[Word_Length-1], acc_q} + {term[Word_Length-1], term};
    if (sum_ext[Word_Length] != sum_ext[Word_Length-1]) begin
      acc_next = sum_ext[Word_Length] ? SatMin : SatMax;
    end else begin
      acc_next = sum_ext[Word_Length-1:0];
    end
  end
`else
  assign acc_next = acc_q + term;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rv_d     = rv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            result_d = acc_next;
            rv_d     = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (result_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_fixed_point_dot_product.sv
// Directed self-checking bench for fixed_point_dot_product (Q3.3, 4 beats).
module tb_fixed_point_dot_product;

  localparam int W  = 6;
  localparam int VL = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic signed [W-1:0] a_in;
  logic signed [W-1:0] b_in;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] result;
  logic                result_valid;
  logic                result_ready;
  logic                busy;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    string             name;
    logic [3:0][W-1:0] a;
    logic [3:0][W-1:0] b;
    int                exp;
  } vec_t;

  fixed_point_dot_product #(
    .Word_Length  (W),
    .Integer_Part (3),
    .Vector_Length(VL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a_in        (a_in),
    .b_in        (b_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input int a0, input int a1, input int a2,
                              input int a3, input int b0, input int b1, input int b2,
                              input int b3, input int exp);
    vec_t v;
    v.name = name;
    v.a[0] = W'(a0); v.a[1] = W'(a1); v.a[2] = W'(a2); v.a[3] = W'(a3);
    v.b[0] = W'(b0); v.b[1] = W'(b1); v.b[2] = W'(b2); v.b[3] = W'(b3);
    v.exp  = exp;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int t0;
    int lat;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    check({v.name, "_in_ready"}, int'(in_ready), 1);
    check({v.name, "_busy"}, int'(busy), 1);
    in_valid = 1'b1;
    for (int i = 0; i < VL; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check({v.name, "_rv_early"}, int'(result_valid), 0);
      end
      a_in = v.a[i];
      b_in = v.b[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !result_valid; n++) @(negedge clk);
    lat = cyc - t0;
    check({v.name, "_rv"}, int'(result_valid), 1);
    check({v.name, "_result"}, int'(result), v.exp);
    check({v.name, "_latency"}, lat, VL + 1);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({v.name, "_rv_ack"}, int'(result_valid), 0);
    check({v.name, "_busy_ack"}, int'(busy), 0);
    check({v.name, "_result_hold"}, int'(result), v.exp);
  endtask

  vec_t vecs[6];

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
    a_in = '0; b_in = '0;

    // Terms: 4*4=16>>3=2; -8*4=-32>>3=-4; 8*12=96>>3=12; 1*1>>3=0;
    // -1*1=-1>>3=-1 (floor), 3*-5=-15>>3=-2, 7*2=14>>3=1, -3*-3=9>>3=1; -8*31=-248>>3=-31.
    vecs[0] = mk("half_sq",  4, 4, 4, 4,  4, 4, 4, 4,  8);
    vecs[1] = mk("neg_half", -8, -8, -8, -8,  4, 4, 4, 4,  -16);
`ifdef FIXED_POINT_SATURATE_EN
    vecs[2] = mk("pos_ovf",  8, 8, 8, 8,  12, 12, 12, 12,  31);
    vecs[5] = mk("neg_ovf",  -8, -8, -8, -8,  31, 31, 31, 31,  -32);
`else
    vecs[2] = mk("pos_ovf",  8, 8, 8, 8,  12, 12, 12, 12,  -16);
    vecs[5] = mk("neg_ovf",  -8, -8, -8, -8,  31, 31, 31, 31,  4);
`endif
    vecs[3] = mk("trunc0",   1, 1, 1, 1,  1, 1, 1, 1,  0);
    vecs[4] = mk("mixed",    -1, 3, 7, -3,  1, -5, 2, -3,  -1);

    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_result", int'(result), 0);
    check("rst_rv", int'(result_valid), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Gapped input, stalled consumer, start pulses in DONE; invalid beats carry poison.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      a_in     = in_valid ? 6'sd2 : 6'sd31;
      b_in     = in_valid ? 6'sd8 : 6'sd31;
      @(negedge clk);
      check("gap_rv", int'(result_valid), (i == 6) ? 1 : 0);
      check("gap_in_ready", int'(in_ready), (i == 6) ? 0 : 1);
    end
    in_valid = 1'b0;
    check("gap_result", int'(result), 8);
    for (int j = 0; j < 3; j++) begin
      start = (j == 1);
      @(negedge clk);
      check("stall_rv", int'(result_valid), 1);
      check("stall_result", int'(result), 8);
      check("stall_busy", int'(busy), 1);
    end
    start        = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    result_ready = 1'b0;
    check("ack_rv", int'(result_valid), 0);
    check("ack_busy", int'(busy), 0);
    check("ack_result", int'(result), 8);
    check("ack_start_ignored", int'(in_ready), 0);
    @(negedge clk);
    check("idle_stays", int'(in_ready), 0);

    // Asynchronous reset after two of four beats.
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    a_in     = 6'sd8;
    b_in     = 6'sd8;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_result", int'(result), 0);
    check("arst_rv", int'(result_valid), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
